// File: rtl/seven_segment_scan_controller.sv
// Scan controller for a 4-digit common-anode display sharing one nibble decoder.
// Double-buffered display word that commits at frame boundaries, with blanking and leading-zero suppression.
module seven_segment_scan_controller #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 8,
  parameter int LZ_BLANK     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic [3:0]  en_in,
  input  logic        load,
  output logic        load_ack,
  output logic [3:0]  digit_val,
  output logic [3:0]  anode_n,
  output logic        frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {BLANK, SHOW} phase_t;

  phase_t          phase_reg, phase_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [1:0]      idx_reg, idx_next;
  logic [15:0]     active_word_reg, word_next;
  logic [3:0]      active_en_reg, en_next;
  logic [15:0]     pend_word_reg;
  logic [3:0]      pend_en_reg;
  logic            pend_flag_reg;
  logic            wrap, boundary, commit;
  logic [3:0]      anode_next;
  logic [3:0]      visible;
  logic [3:0]      nib [4];

  assign wrap     = (cnt_reg == CW'(REFRESH_DIV - 1));
  assign boundary = wrap && (idx_reg == 2'd3);
  assign commit   = boundary && pend_flag_reg;

  // Outputs are registered from the state that will hold after this edge,
  // including a word committed on this edge.
  assign word_next = commit ? pend_word_reg : active_word_reg;
  assign en_next   = commit ? pend_en_reg   : active_en_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign nib[gi] = word_next[4*gi +: 4];
      if (gi == 0) begin : g_first
        assign visible[gi] = en_next[gi];
      end else begin : g_upper
        assign visible[gi] = en_next[gi] &&
                             !((LZ_BLANK != 0) && (word_next[15:4*gi] == '0));
      end
    end
  endgenerate

  always_comb begin
    phase_next = phase_reg;
    cnt_next   = wrap ? '0 : cnt_reg + 1'b1;
    idx_next   = wrap ? idx_reg + 2'd1 : idx_reg;
    anode_next = 4'b1111;
    case (phase_reg)
      BLANK:   if (cnt_reg == CW'(BLANK_CYCLES - 1)) phase_next = SHOW;
      SHOW:    if (wrap) phase_next = BLANK;
      default: phase_next = BLANK;
    endcase
    if (phase_next == SHOW && visible[idx_next]) anode_next[idx_next] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_reg       <= BLANK;
      cnt_reg         <= '0;
      idx_reg         <= 2'd0;
      active_word_reg <= '0;
      active_en_reg   <= '0;
      pend_word_reg   <= '0;
      pend_en_reg     <= '0;
      pend_flag_reg   <= 1'b0;
      anode_n         <= 4'b1111;
      digit_val       <= 4'd0;
      load_ack        <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      phase_reg       <= phase_next;
      cnt_reg         <= cnt_next;
      idx_reg         <= idx_next;
      active_word_reg <= word_next;
      active_en_reg   <= en_next;
      anode_n         <= anode_next;
      digit_val       <= nib[idx_next];
      load_ack        <= commit;
      frame_done      <= boundary;
      // A load coinciding with a commit stays pending for the next frame.
      if (load) begin
        pend_word_reg <= value_in;
        pend_en_reg   <= en_in;
        pend_flag_reg <= 1'b1;
      end else if (commit) begin
        pend_flag_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Randomized and directed bench for seven_segment_scan_controller, with and without
// leading-zero blanking, compared against a time-based reference model.
module tb_seven_segment_scan_controller;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  en_in = '0;
  logic        load = 1'b0;
  logic        ack1, fd1, ack0, fd0;
  logic [3:0]  dv1, an1, dv0, an0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: cycles since reset release plus the two buffers.
  int          m_t = 0;
  logic [15:0] m_act = '0, m_pend = '0;
  logic [3:0]  m_act_en = '0, m_pend_en = '0;
  bit          m_flag = 0, m_ack = 0, m_fd = 0;

  always #5 clk = ~clk;

  seven_segment_scan_controller #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_BLANK(1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .en_in(en_in), .load(load),
    .load_ack(ack1), .digit_val(dv1), .anode_n(an1), .frame_done(fd1));

  seven_segment_scan_controller #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_BLANK(0)) dut_all (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .en_in(en_in), .load(load),
    .load_ack(ack0), .digit_val(dv0), .anode_n(an0), .frame_done(fd0));

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d observed=%h expected=%h", tag, m_t, obs, exp);
    end
  endtask

  function automatic bit vis(input int k, input bit lz);
    if (!m_act_en[k]) return 0;
    if (k == 0 || !lz) return 1;
    return (m_act >> (4 * k)) != 0;
  endfunction

  function automatic logic [3:0] exp_anode(input bit lz);
    int c = m_t % RD;
    int k = (m_t / RD) % 4;
    if (c >= BC && vis(k, lz)) return ~(4'b0001 << k);
    return 4'b1111;
  endfunction

  task automatic model_edge();
    bit bnd;
    if (!rst_n) begin
      m_t = 0; m_act = '0; m_act_en = '0; m_pend = '0; m_pend_en = '0;
      m_flag = 0; m_ack = 0; m_fd = 0;
    end else begin
      bnd   = (m_t % FRAME) == FRAME - 1;
      m_fd  = bnd;
      m_ack = bnd && m_flag;
      if (bnd && m_flag) begin
        m_act = m_pend; m_act_en = m_pend_en; m_flag = 0;
      end
      if (load) begin
        m_pend = value_in; m_pend_en = en_in; m_flag = 1;
      end
      m_t++;
    end
  endtask

  task automatic step();
    logic [3:0] dexp;
    @(posedge clk);
    model_edge();
    #1;
    dexp = 4'((m_act >> (4 * ((m_t / RD) % 4))) & 16'hF);
    check_eq("anode_lz",  {12'd0, an1}, {12'd0, exp_anode(1)});
    check_eq("anode_all", {12'd0, an0}, {12'd0, exp_anode(0)});
    check_eq("digit_lz",  {12'd0, dv1}, {12'd0, dexp});
    check_eq("digit_all", {12'd0, dv0}, {12'd0, dexp});
    check_eq("load_ack",  {14'd0, ack1, ack0}, {14'd0, m_ack, m_ack});
    check_eq("frame_done", {14'd0, fd1, fd0}, {14'd0, m_fd, m_fd});
    check_eq("onehot", {14'd0, $countones(~an1) <= 1, $countones(~an0) <= 1}, 16'd3);
    if (m_ack) $display("ack t=%0d active=%h en=%b", m_t, m_act, m_act_en);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] e);
    $display("load t=%0d value=%h en=%b", m_t, v, e);
    value_in = v; en_in = e; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Advance until the next edge will be sampled at frame position pos.
  task automatic align(input int pos);
    for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != pos; i++) step();
  endtask

  initial begin
    // Reset held with a load strobe that must be discarded.
    rst_n = 1'b0; load = 1'b1; value_in = 16'h9999; en_in = 4'hF;
    run(3);
    load = 1'b0; rst_n = 1'b1;
    run(FRAME + 8);

    do_load(16'h1234, 4'b1111);
    run(2 * FRAME);
    do_load(16'h0050, 4'b1111);
    run(2 * FRAME);
    do_load(16'h0000, 4'b1111);
    run(2 * FRAME);
    do_load(16'hFFFF, 4'b0101);
    run(2 * FRAME);

    // Two loads in one frame: last write wins, one ack.
    align(12); do_load(16'hAAAA, 4'hF);
    align(20); do_load(16'hBBBB, 4'hF);
    run(FRAME + 4);

    // Pending word plus a load on the commit cycle itself.
    align(5);  do_load(16'h0C0D, 4'hF);
    align(FRAME - 1); do_load(16'hE0F1, 4'b1011);
    run(2 * FRAME + 4);

    // Reset while slot 2 is showing, with a load pending.
    do_load(16'h4321, 4'hF);
    align(21);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    run(2 * FRAME);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0; step(); rst_n = 1'b1;
      end else if ($urandom_range(0, 14) == 0) begin
        do_load(16'($urandom) >> (4 * $urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      end else begin
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
